alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 85 ++++++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_alu.sv | 58 +++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 16-bit ALU sequencer.
// Holds request opcodes, FSM states, flag bit positions and alu opcodes.
package alu_seq_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_ADD = 4'b0110;
   localparam logic [3:0] ALU_SUB = 4'b0111;
   localparam logic [3:0] ALU_NOT = 4'b1000;
   localparam logic [3:0] ALU_INC = 4'b1010;
   localparam logic [3:0] ALU_DEC = 4'b1011;

   localparam int FLAG_CF = 0;
   localparam int FLAG_PF = 1;
   localparam int FLAG_VF = 2;
   localparam int FLAG_AF = 3;
   localparam int FLAG_ZF = 4;
   localparam int FLAG_SF = 5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LO   = 3'd1,
      S_HI   = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   function automatic logic op_legal(
      input logic [2:0] op
   );
      return op <= OP_NOT;
   endfunction

   function automatic logic [3:0] map_op(
      input logic [2:0] op
   );
      logic [3:0] m;
      m = ALU_AND;
      unique case (op)
         OP_AND:  m = ALU_AND;
         OP_OR:   m = ALU_OR;
         OP_XOR:  m = ALU_XOR;
         OP_ADD:  m = ALU_ADD;
         OP_SUB:  m = ALU_SUB;
         OP_NOT:  m = ALU_NOT;
         default: m = ALU_AND;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] make_flags(
      input logic [2:0]  op,
      input logic [15:0] a,
      input logic [15:0] b,
      input logic [15:0] c,
      input logic        af,
      input logic        cf
   );
      logic [7:0] f;
      logic       is_add;
      logic       is_sub;
      is_add = (op == OP_ADD);
      is_sub = (op == OP_SUB);
      f = 8'h00;
      f[FLAG_ZF] = (c == 16'h0000);
      f[FLAG_SF] = c[15];
      f[FLAG_PF] = ~^c[7:0];
      f[FLAG_AF] = (is_add | is_sub) & af;
      f[FLAG_CF] = (is_add | is_sub) & cf;
      f[FLAG_VF] = (is_add & (a[15] == b[15])
                   & (a[15] != c[15]))
                 | (is_sub & (a[15] != b[15])
                   & (a[15] != c[15]));
      return f;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle for the ALU sequencer.
// master = requester/consumer side, slave = sequencer side.
interface alu_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_c;
   logic [7:0]  rsp_flags;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_c,
      input  rsp_flags, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_c,
      output rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_seq_alu.sv
// Combinational 8-bit alu shared by every sequencer step.
// co is carry for ADD/INC and borrow for SUB/DEC.
module alu_seq_alu
   import alu_seq_pkg::*;
(
   input  logic [3:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] cpu_flags,
   output logic [7:0] y,
   output logic       co,
   output logic       af
);

   logic [8:0] s;
   logic [4:0] h;
   logic       unused_flags;

   assign unused_flags = ^cpu_flags;

   always_comb begin
      y  = 8'h00;
      co = 1'b0;
      af = 1'b0;
      s  = 9'h000;
      h  = 5'h00;
      unique case (op)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_NOT: y = ~a;
         ALU_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            h = {1'b0, a[3:0]} + {1'b0, b[3:0]};
         end
         ALU_SUB: begin
            s = {1'b0, a} - {1'b0, b};
            h = {1'b0, a[3:0]} - {1'b0, b[3:0]};
         end
         ALU_INC: begin
            s = {1'b0, a} + 9'h001;
            h = {1'b0, a[3:0]} + 5'h01;
         end
         ALU_DEC: begin
            s = {1'b0, a} - 9'h001;
            h = {1'b0, a[3:0]} - 5'h01;
         end
         default: y = 8'h00;
      endcase
      if (op == ALU_ADD || op == ALU_SUB ||
          op == ALU_INC || op == ALU_DEC) begin
         y  = s[7:0];
         co = s[8];
         af = h[4];
      end
   end

endmodule

// File: rtl/alu_seq.sv
// 16-bit ALU sequencer: runs an 8-bit alu over low byte, high byte,
// then an optional INC/DEC fix step to propagate carry/borrow.
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);

   state_e      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  lo_q, lo_d;
   logic        lo_c_q, lo_c_d;
   logic        af_q, af_d;
   logic [7:0]  hi_q, hi_d;
   logic        hi_c_q, hi_c_d;
   logic [15:0] rsp_c_q, rsp_c_d;
   logic [7:0]  rsp_f_q, rsp_f_d;
   logic        rsp_e_q, rsp_e_d;

   logic [3:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_y;
   logic        alu_co;
   logic        alu_af;
   logic        is_arith;

   alu_seq_alu u_alu (
      .op        (alu_op),
      .a         (alu_a),
      .b         (alu_b),
      .cpu_flags (8'h00),
      .y         (alu_y),
      .co        (alu_co),
      .af        (alu_af)
   );

   assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      lo_d    = lo_q;
      lo_c_d  = lo_c_q;
      af_d    = af_q;
      hi_d    = hi_q;
      hi_c_d  = hi_c_q;
      rsp_c_d = rsp_c_q;
      rsp_f_d = rsp_f_q;
      rsp_e_d = rsp_e_q;
      alu_op  = ALU_AND;
      alu_a   = 8'h00;
      alu_b   = 8'h00;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d = bus.req_op;
               a_d  = bus.req_a;
               b_d  = bus.req_b;
               if (op_legal(bus.req_op)) begin
                  state_d = S_LO;
               end else begin
                  state_d = S_DONE;
                  rsp_c_d = 16'h0000;
                  rsp_f_d = 8'h00;
                  rsp_e_d = 1'b1;
               end
            end
         end
         S_LO: begin
            alu_op  = map_op(op_q);
            alu_a   = a_q[7:0];
            alu_b   = b_q[7:0];
            lo_d    = alu_y;
            lo_c_d  = alu_co;
            af_d    = is_arith & alu_af;
            state_d = S_HI;
         end
         S_HI: begin
            alu_op = map_op(op_q);
            alu_a  = a_q[15:8];
            alu_b  = b_q[15:8];
            hi_d   = alu_y;
            hi_c_d = alu_co;
            if (is_arith && lo_c_q) begin
               state_d = S_FIX;
            end else begin
               state_d = S_DONE;
               rsp_c_d = {alu_y, lo_q};
               rsp_f_d = make_flags(op_q, a_q, b_q,
                                    {alu_y, lo_q},
                                    af_q, alu_co);
               rsp_e_d = 1'b0;
            end
         end
         S_FIX: begin
            alu_op  = (op_q == OP_ADD) ? ALU_INC : ALU_DEC;
            alu_a   = hi_q;
            state_d = S_DONE;
            rsp_c_d = {alu_y, lo_q};
            rsp_f_d = make_flags(op_q, a_q, b_q,
                                 {alu_y, lo_q},
                                 af_q, hi_c_q | alu_co);
            rsp_e_d = 1'b0;
         end
         S_DONE: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 3'b000;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         lo_q    <= 8'h00;
         lo_c_q  <= 1'b0;
         af_q    <= 1'b0;
         hi_q    <= 8'h00;
         hi_c_q  <= 1'b0;
         rsp_c_q <= 16'h0000;
         rsp_f_q <= 8'h00;
         rsp_e_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         lo_q    <= lo_d;
         lo_c_q  <= lo_c_d;
         af_q    <= af_d;
         hi_q    <= hi_d;
         hi_c_q  <= hi_c_d;
         rsp_c_q <= rsp_c_d;
         rsp_f_q <= rsp_f_d;
         rsp_e_q <= rsp_e_d;
      end
   end

   assign bus.req_ready = rst_n && (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.rsp_c     = rsp_c_q;
   assign bus.rsp_flags = rsp_f_q;
   assign bus.rsp_err   = rsp_e_q;

endmodule
